// File: rtl/booth_sequencer.sv
// Radix-4 Booth multiply sequencer: 8 RUN cycles accumulate external partial products.
// Optional BOOTH_OVERFLOW_DETECT_EN widens the accumulator to 48 bits and flags overflow.
module booth_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [15:0] operand_b,
  output logic [31:0] booth_multiplicand,
  output logic [15:0] booth_multiplier,
  output logic [2:0]  booth_counter,
  input  logic [31:0] booth_pp,
  input  logic        booth_carry,
  output logic [31:0] result,
  output logic        result_rdy,
  output logic        busy,
  output logic        overflow
);

`ifdef BOOTH_OVERFLOW_DETECT_EN
  localparam int AW = 48;
`else
  localparam int AW = 32;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [2:0]    count;
  logic [AW-1:0] acc;
  logic [AW-1:0] term;
  logic [AW-1:0] acc_sum;
  logic          ovf_next;

  always_comb begin
    term     = '0;
    acc_sum  = '0;
    ovf_next = 1'b0;
`ifdef BOOTH_OVERFLOW_DETECT_EN
    term = {{(AW-33){booth_carry}}, booth_carry, booth_pp};
    term = term << {count, 1'b0};
    acc_sum = acc + term;
    ovf_next = acc_sum[47:32] != {16{acc_sum[31]}};
`else
    term = booth_pp << {count, 1'b0};
    acc_sum = acc + term;
`endif
  end

  assign booth_counter = (state == RUN) ? count : 3'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      count              <= 3'd0;
      acc                <= '0;
      result             <= 32'd0;
      result_rdy         <= 1'b0;
      busy               <= 1'b0;
      overflow           <= 1'b0;
      booth_multiplicand <= 32'd0;
      booth_multiplier   <= 16'd0;
    end else begin
      result_rdy <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state              <= RUN;
            booth_multiplicand <= operand_a;
            booth_multiplier   <= operand_b;
            acc                <= '0;
            count              <= 3'd0;
            busy               <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_sum;
          count <= count + 3'd1;
          if (count == 3'd7) begin
            state      <= DONE;
            result     <= acc_sum[31:0];
            overflow   <= ovf_next;
            result_rdy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: directed and random multiplies vs plain arithmetic.
// A behavioural radix-4 partial-product block answers the DUT's digit requests.
module tb_booth_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] operand_a;
  logic [15:0] operand_b;
  logic [31:0] booth_multiplicand;
  logic [15:0] booth_multiplier;
  logic [2:0]  booth_counter;
  logic [31:0] booth_pp;
  logic        booth_carry;
  logic [31:0] result;
  logic        result_rdy;
  logic        busy;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  booth_sequencer dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .booth_multiplicand(booth_multiplicand),
    .booth_multiplier(booth_multiplier),
    .booth_counter(booth_counter),
    .booth_pp(booth_pp),
    .booth_carry(booth_carry),
    .result(result),
    .result_rdy(result_rdy),
    .busy(busy),
    .overflow(overflow)
  );

  // Digit value d = -2*b[2i+1] + b[2i] + b[2i-1]; product returned 33 bits wide.
  function automatic logic [32:0] pp_model(
    input logic [31:0] a,
    input logic [15:0] b,
    input logic [2:0]  i
  );
    logic [16:0] bx;
    int          k;
    int          d;
    longint      p;
    bx = {b, 1'b0};
    k  = int'(i) * 2;
    d  = -2 * int'(bx[k+2]) + int'(bx[k+1]) + int'(bx[k]);
    p  = longint'($signed(a)) * longint'(d);
    return p[32:0];
  endfunction

  always_comb begin
    {booth_carry, booth_pp} =
      pp_model(booth_multiplicand, booth_multiplier, booth_counter);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_res(input logic [31:0] a,
                                          input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic exp_ovf(input logic [31:0] a,
                                   input logic [15:0] b);
`ifdef BOOTH_OVERFLOW_DETECT_EN
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return (p > 64'sd2147483647) || (p < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge just before the accepting edge; returns at cycle 10.
  task automatic op(input logic [31:0] a, input logic [15:0] b,
                    input bit keep, input bit poke);
    logic [31:0] er;
    logic        eo;
    er        = exp_res(a, b);
    eo        = exp_ovf(a, b);
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clock);
      if (cyc == 1 && !keep) start = 1'b0;
      if (poke && cyc == 3) begin
        start     = 1'b1;
        operand_a = 32'd9;
      end
      if (poke && cyc == 9) start = 1'b0;
      if (cyc <= 9) begin
        chk("busy", 64'(busy), 64'(1));
        chk("rdy", 64'(result_rdy), 64'(cyc == 9));
        chk("mcand", 64'(booth_multiplicand), 64'(a));
      end
      if (cyc <= 8) chk("counter", 64'(booth_counter), 64'(cyc - 1));
      if (cyc == 9) begin
        chk("result", 64'(result), 64'(er));
        chk("overflow", 64'(overflow), 64'(eo));
        chk("counter_done", 64'(booth_counter), 64'(0));
      end
      if (cyc == 10) begin
        chk("busy_idle", 64'(busy), 64'(0));
        chk("rdy_idle", 64'(result_rdy), 64'(0));
        chk("result_hold", 64'(result), 64'(er));
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_result"}, 64'(result), 64'(0));
    chk({tag, "_rdy"}, 64'(result_rdy), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_mcand"}, 64'(booth_multiplicand), 64'(0));
    chk({tag, "_mplier"}, 64'(booth_multiplier), 64'(0));
    chk({tag, "_cnt"}, 64'(booth_counter), 64'(0));
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    reset     = 1'b1;
    start     = 1'b0;
    operand_a = 32'd0;
    operand_b = 16'd0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    op(32'd3, 16'd5, 1'b0, 1'b0);
    op(-32'sd7, 16'd6, 1'b0, 1'b0);
    op(32'h7FFF_FFFF, 16'd2, 1'b0, 1'b0);
    op(32'd3, 16'd5, 1'b0, 1'b1);
    op(32'h8000_0000, 16'h8000, 1'b0, 1'b0);
    op(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0);

    // Abort mid-run at digit 4.
    start     = 1'b1;
    operand_a = 32'd3;
    operand_b = 16'd5;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort_cnt_pre", 64'(booth_counter), 64'(4));
    reset = 1'b1;
    #1;
    chk_zero("abort");
    repeat (10) begin
      @(negedge clock);
      chk("abort_rdy", 64'(result_rdy), 64'(0));
    end
    reset = 1'b0;
    @(negedge clock);
    op(32'd2, -16'sd3, 1'b0, 1'b0);

    // Back-to-back with start held high.
    for (int n = 0; n < 4; n++) begin
      ra = $urandom;
      rb = 16'($urandom);
      op(ra, rb, 1'b1, 1'b0);
    end
    start = 1'b0;
    @(negedge clock);

    for (int n = 0; n < 12; n++) begin
      ra = $urandom;
      rb = 16'($urandom);
      if (n % 3 == 0) ra = 32'($urandom_range(0, 200)) - 32'd100;
      op(ra, rb, 1'b0, n % 4 == 1);
      if (n % 2 == 0) @(negedge clock);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
